// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Purpose  : Receives frames from the same-clock serial transmitter.
//            A frame is one low start bit followed by DATA_WIDTH data bits,
//            LSB first, one bit per clock. The bit after the data must be
//            high. A good frame updates rx_data_o with a one-cycle
//            rx_valid_o pulse. A low post-data bit gives a one-cycle
//            frame_err_o pulse, and the receiver then waits for the line
//            to go high again before it looks for a new start bit.
// Ports    : clk_i        system clock, rising edge
//            rst_ni       asynchronous active-low reset
//            rx_in_i      serial line, idles high
//            rx_data_o    last correctly framed word, held between frames
//            rx_valid_o   one-cycle pulse, rx_data_o updated this cycle
//            frame_err_o  one-cycle pulse, post-data bit was low
//            rx_busy_o    high while a frame is in progress or in resync
// Options  : SERIAL_RX_SYNC_EN - when defined, rx_in_i passes through a
//            2-flop synchroniser (reset to 1), which adds 2 cycles to all
//            latencies. When undefined, rx_in_i must come from clk_i's domain.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_in_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  frame_err_o,
  output logic                  rx_busy_o
);

  localparam int                c_cnt_w    = $clog2(DATA_WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2,
    RESYNC = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    line_s;

`ifdef SERIAL_RX_SYNC_EN
  // The synchroniser resets to the idle level so that a reset cannot
  // create a false start bit.
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign line_s = sync2_q;
`else
  assign line_s = rx_in_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Any low sample is a start bit. There is no glitch filter.
        if (!line_s) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end

      DATA: begin
        shift_d[cnt_q] = line_s;
        // The counter stops at the last bit index and never wraps. It is
        // cleared again on the next entry to DATA.
        if (cnt_q == c_last_bit) begin
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      STOP: begin
        if (line_s) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = RESYNC;
        end
      end

      RESYNC: begin
        // A low line here is still the tail of a bad frame. It is not
        // taken as a start bit.
        if (line_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = err_q;
  assign rx_busy_o   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_rx
// Purpose  : Self-checking bench for serial_rx. Line streams are built as
//            bit queues. A frame parser derives the expected per-cycle
//            outputs from the framing rules, and the bench compares them
//            with the DUT. Build with SERIAL_RX_SYNC_EN to cover the
//            synchroniser variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_rx;

  localparam int DW   = 8;
  localparam int MAXN = 1024;
`ifdef SERIAL_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          rx_busy;

  serial_rx #(.DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_in_i     (rx_in),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err),
    .rx_busy_o   (rx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Current line stream, one entry per cycle.
  bit            line_q[$];
  // Expected value of rx_data carried across streams.
  logic [DW-1:0] held = '0;
  int            run_n;

  logic          ev_v[MAXN], ev_e[MAXN], ev_b[MAXN];
  logic [DW-1:0] ev_d[MAXN];
  logic          ob_v[MAXN], ob_e[MAXN], ob_b[MAXN];
  logic [DW-1:0] ob_d[MAXN];

  // --------------------------------------------------------------------------
  // Stream construction
  // --------------------------------------------------------------------------
  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) line_q.push_back(1'b1);
  endtask

  // Pushes a start bit, the data LSB first, and a post-data bit (1 if good).
  // Then pushes low_extra more low cycles and gap extra high cycles.
  task automatic push_frame(input logic [DW-1:0] w, input bit good,
                            input int low_extra, input int gap);
    line_q.push_back(1'b0);
    for (int b = 0; b < DW; b++) line_q.push_back(w[b]);
    line_q.push_back(good);
    for (int i = 0; i < low_extra; i++) line_q.push_back(1'b0);
    push_ones(gap);
  endtask

  // --------------------------------------------------------------------------
  // Reference: a frame parser that works from the framing rules.
  // A start bit seen in cycle k gives data in k+1..k+DW, the post-data bit
  // in k+DW+1, and the result pulse in k+DW+2. The receiver is busy from
  // k+1 to the post-data bit. After a bad post-data bit it stays busy until
  // the cycle that sees the line high again.
  // --------------------------------------------------------------------------
  task automatic model_stream();
    bit            eff[MAXN];
    logic          upd[MAXN];
    logic [DW-1:0] upd_w[MAXN];
    logic [DW-1:0] w, cur;
    int            k, j, ev;
    run_n = line_q.size();
    for (int c = 0; c < run_n; c++) begin
      eff[c]  = (c < LAT) ? 1'b1 : line_q[c-LAT];
      ev_v[c] = 1'b0;
      ev_e[c] = 1'b0;
      ev_b[c] = 1'b0;
      upd[c]  = 1'b0;
    end
    k = 0;
    while (k < run_n) begin
      if (eff[k] == 1'b0) begin
        ev = k + DW + 2;
        if (ev >= run_n) break;
        for (int b = 0; b < DW; b++) w[b] = eff[k+1+b];
        for (int c = k + 1; c <= k + DW + 1; c++) ev_b[c] = 1'b1;
        if (eff[k+DW+1]) begin
          ev_v[ev]  = 1'b1;
          upd[ev]   = 1'b1;
          upd_w[ev] = w;
          k = ev;
        end else begin
          ev_e[ev] = 1'b1;
          j = ev;
          while (j < run_n && eff[j] == 1'b0) begin
            ev_b[j] = 1'b1;
            j++;
          end
          if (j < run_n) ev_b[j] = 1'b1;
          k = j + 1;
        end
      end else begin
        k++;
      end
    end
    cur = held;
    for (int c = 0; c < run_n; c++) begin
      if (upd[c]) cur = upd_w[c];
      ev_d[c] = cur;
    end
    held = cur;
  endtask

  // Drives line_q one bit per cycle and captures the outputs of each cycle.
  task automatic drive_stream();
    model_stream();
    for (int c = 0; c < run_n; c++) begin
      @(posedge clk);
      #1;
      rx_in   = line_q[c];
      ob_v[c] = rx_valid;
      ob_e[c] = frame_err;
      ob_b[c] = rx_busy;
      ob_d[c] = rx_data;
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== {{DW{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_hold got data/v/e/b=%h/%b/%b/%b want 00/0/0/0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== {{DW{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_release got data/v/e/b=%h/%b/%b/%b want 00/0/0/0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
    held = '0;
  endtask

  task automatic test_idle();
    int pulses;
    line_q.delete();
    push_ones(50);
    drive_stream();
    pulses = 0;
    for (int c = 0; c < run_n; c++) begin
      n_cmp++;
      if ({ob_v[c], ob_e[c], ob_b[c], ob_d[c]} !== {ev_v[c], ev_e[c], ev_b[c], ev_d[c]}) begin
        n_fail++;
        $display("FAIL idle_stream cyc=%0d got v/e/b/d=%b/%b/%b/%h want %b/%b/%b/%h",
                 c, ob_v[c], ob_e[c], ob_b[c], ob_d[c], ev_v[c], ev_e[c], ev_b[c], ev_d[c]);
      end
      if (ob_v[c] === 1'b1 || ob_e[c] === 1'b1 || ob_b[c] !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_single();
    int nv, idx;
    line_q.delete();
    push_ones(10);
    push_frame(8'hA5, 1'b1, 0, 8);
    drive_stream();
    nv  = 0;
    idx = -1;
    for (int c = 0; c < run_n; c++) begin
      n_cmp++;
      if ({ob_v[c], ob_e[c], ob_b[c], ob_d[c]} !== {ev_v[c], ev_e[c], ev_b[c], ev_d[c]}) begin
        n_fail++;
        $display("FAIL single_a5 cyc=%0d got v/e/b/d=%b/%b/%b/%h want %b/%b/%b/%h",
                 c, ob_v[c], ob_e[c], ob_b[c], ob_d[c], ev_v[c], ev_e[c], ev_b[c], ev_d[c]);
      end
      if (ob_v[c] === 1'b1) begin
        nv++;
        idx = c;
      end
    end
    n_cmp++;
    if (nv !== 1 || idx !== 20 + LAT) begin
      n_fail++;
      $display("FAIL single_a5_timing got %0d pulses last at cycle %0d want 1 at cycle %0d",
               nv, idx, 20 + LAT);
    end
    n_cmp++;
    if (idx >= 0 && ob_d[idx] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_a5_data got %h want a5", ob_d[idx]);
    end
  endtask

  task automatic test_framing_err();
    int ne, nv, eidx, vidx;
    line_q.delete();
    push_ones(3);
    push_frame(8'h55, 1'b0, 3, 1);
    push_frame(8'h12, 1'b1, 0, 6);
    drive_stream();
    ne = 0; nv = 0; eidx = -1; vidx = -1;
    for (int c = 0; c < run_n; c++) begin
      n_cmp++;
      if ({ob_v[c], ob_e[c], ob_b[c], ob_d[c]} !== {ev_v[c], ev_e[c], ev_b[c], ev_d[c]}) begin
        n_fail++;
        $display("FAIL framing_err cyc=%0d got v/e/b/d=%b/%b/%b/%h want %b/%b/%b/%h",
                 c, ob_v[c], ob_e[c], ob_b[c], ob_d[c], ev_v[c], ev_e[c], ev_b[c], ev_d[c]);
      end
      if (ob_e[c] === 1'b1) begin ne++; eidx = c; end
      if (ob_v[c] === 1'b1) begin nv++; vidx = c; end
    end
    n_cmp++;
    if (ne !== 1 || eidx !== 3 + DW + 2 + LAT || ob_d[eidx] !== 8'hA5) begin
      n_fail++;
      $display("FAIL framing_err_pulse got %0d pulses at cycle %0d data %h want 1 at %0d data a5",
               ne, eidx, (eidx >= 0) ? ob_d[eidx] : 8'h00, 3 + DW + 2 + LAT);
    end
    n_cmp++;
    if (nv !== 1 || vidx < 0 || ob_d[vidx] !== 8'h12) begin
      n_fail++;
      $display("FAIL framing_err_recover got %0d valid pulses data %h want 1 with data 12",
               nv, (vidx >= 0) ? ob_d[vidx] : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    int vi[$];
    line_q.delete();
    push_ones(2);
    push_frame(8'h3C, 1'b1, 0, 0);
    push_frame(8'hFF, 1'b1, 0, 6);
    drive_stream();
    for (int c = 0; c < run_n; c++) begin
      n_cmp++;
      if ({ob_v[c], ob_e[c], ob_b[c], ob_d[c]} !== {ev_v[c], ev_e[c], ev_b[c], ev_d[c]}) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got v/e/b/d=%b/%b/%b/%h want %b/%b/%b/%h",
                 c, ob_v[c], ob_e[c], ob_b[c], ob_d[c], ev_v[c], ev_e[c], ev_b[c], ev_d[c]);
      end
      if (ob_v[c] === 1'b1) vi.push_back(c);
    end
    n_cmp++;
    if (vi.size() !== 2) begin
      n_fail++;
      $display("FAIL back_to_back_count got %0d valid pulses want 2", vi.size());
    end else begin
      n_cmp++;
      if (vi[1] - vi[0] !== 10 || ob_d[vi[0]] !== 8'h3C || ob_d[vi[1]] !== 8'hFF) begin
        n_fail++;
        $display("FAIL back_to_back_words got spacing %0d data %h,%h want 10 data 3c,ff",
                 vi[1] - vi[0], ob_d[vi[0]], ob_d[vi[1]]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    line_q.delete();
    push_ones(2);
    push_frame(8'hF0, 1'b1, 0, 4);
    // Data bit 4 is on the line in cycle 2 + 1 + 4.
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk);
      #1;
      rx_in = line_q[c];
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== {{DW{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_async got data/v/e/b=%h/%b/%b/%b want 00/0/0/0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
    @(posedge clk);
    #1;
    rx_in = 1'b1;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0 || rx_data !== '0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet got %0d active cycles want 0", bad);
    end
    held = '0;
    line_q.delete();
    push_frame(8'h81, 1'b1, 0, 6);
    drive_stream();
    for (int c = 0; c < run_n; c++) begin
      n_cmp++;
      if ({ob_v[c], ob_e[c], ob_b[c], ob_d[c]} !== {ev_v[c], ev_e[c], ev_b[c], ev_d[c]}) begin
        n_fail++;
        $display("FAIL reset_mid_next cyc=%0d got v/e/b/d=%b/%b/%b/%h want %b/%b/%b/%h",
                 c, ob_v[c], ob_e[c], ob_b[c], ob_d[c], ev_v[c], ev_e[c], ev_b[c], ev_d[c]);
      end
    end
    n_cmp++;
    if (rx_data !== 8'h81) begin
      n_fail++;
      $display("FAIL reset_mid_word got %h want 81", rx_data);
    end
  endtask

  task automatic test_random();
    line_q.delete();
    push_ones(2);
    for (int f = 0; f < 30; f++) begin
      logic [DW-1:0] w;
      bit good;
      w    = DW'($urandom);
      good = ($urandom_range(0, 4) != 0);
      push_frame(w, good, good ? 0 : $urandom_range(0, 3), good ? $urandom_range(0, 3)
                                                                : $urandom_range(1, 3));
      // Occasional single-cycle low glitch, which counts as a start bit.
      if ($urandom_range(0, 7) == 0) begin
        line_q.push_back(1'b0);
        for (int b = 0; b < DW; b++) line_q.push_back(1'($urandom));
        push_ones(2);
      end
    end
    push_ones(8);
    drive_stream();
    for (int c = 0; c < run_n; c++) begin
      n_cmp++;
      if ({ob_v[c], ob_e[c], ob_b[c], ob_d[c]} !== {ev_v[c], ev_e[c], ev_b[c], ev_d[c]}) begin
        n_fail++;
        $display("FAIL random_stream cyc=%0d got v/e/b/d=%b/%b/%b/%h want %b/%b/%b/%h",
                 c, ob_v[c], ob_e[c], ob_b[c], ob_d[c], ev_v[c], ev_e[c], ev_b[c], ev_d[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_framing_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receive stage directly downstream of the serial transmit FSM/datapath; consumes its single-bit line.
- Line framing per frame: idle high, one low start bit, then DATA_WIDTH data bits LSB first, one bit per clk, then line high again.
- Deserialises each frame into a parallel word and reports it with a one-cycle valid pulse.
- Flags frames whose post-data bit is low (framing error) and resynchronises on the next idle-high.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line from transmitter; idle = 1.
- rx_data  output  DATA_WIDTH  last correctly framed word; held until the next good frame.
- rx_valid  output  1  one-cycle pulse; rx_data updated this cycle.
- frame_err  output  1  one-cycle pulse; post-data bit sampled low.
- rx_busy  output  1  high in states DATA, STOP and RESYNC.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bit counter=0; shift register=0.
  - rx_data=0, rx_valid=0, frame_err=0, rx_busy=0.
  - Deassertion is sampled on clk; first legal start detection is on the first edge after release.
- Line sample:
  - Without SERIAL_RX_SYNC_EN, rx_in is sampled directly each edge. Transmitter and receiver share clk.
- States (registered state, 2-bit encoding):
  - IDLE: sample 0 -> DATA with counter cleared; sample 1 -> stay IDLE.
  - DATA: shift register bit[count] <= sample; count++.
    - When count==DATA_WIDTH-1 at the edge, store the last bit and go to STOP.
  - STOP, sample 1:
    - rx_data <= assembled word; rx_valid=1 for exactly the next cycle; go to IDLE.
  - STOP, sample 0:
    - frame_err=1 for the next cycle; rx_data unchanged; go to RESYNC.
  - RESYNC: stay until a sample of 1, then go to IDLE. A low line is never taken as a start bit here.
- Timing (no sync):
  - Start bit on line in cycle t.
  - Data bits in cycles t+1..t+DATA_WIDTH.
  - Stop sample in cycle t+DATA_WIDTH+1.
  - rx_valid (or frame_err) high in cycle t+DATA_WIDTH+2.
- Back-to-back frames:
  - The transmitter guarantees at least one high cycle between frames.
  - STOP->IDLE takes that cycle, so a start bit in the immediately following cycle is accepted.
  - rx_valid for frame N and start detection for frame N+1 may coincide; both must occur.
- Pulses:
  - rx_valid and frame_err are never high together.
  - Each is high for exactly one cycle per frame.
- Counter:
  - Width $clog2(DATA_WIDTH).
  - Never exceeds DATA_WIDTH-1.
  - Cleared on entry to DATA.
- Reset mid-frame: partial word is discarded; rx_data returns to 0; no pulse is emitted.
- Glitches: a single low cycle in IDLE is a valid start bit. There is no glitch filtering.

Optional Feature:
- Macro: SERIAL_RX_SYNC_EN.
- Defined:
  - rx_in passes through a 2-flop synchroniser before the FSM. Both flops reset to 1.
  - All latencies grow by 2 cycles: rx_valid is in cycle t+DATA_WIDTH+4.
  - Framing and state behaviour are otherwise identical.
- Undefined:
  - No synchroniser flops; latency as above.
  - Use only when rx_in is driven from the same clk domain.

Test Plan:
1. Frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1), start at cycle 10 -> rx_valid only in cycle 20, rx_data=0xA5, frame_err=0.
2. Back-to-back 0x3C, then 0xFF with a single high cycle between -> two rx_valid pulses, 10 cycles apart; rx_data=0x3C then 0xFF.
3. Frame 0x55 with post-data bit forced 0 and the line held low for 3 more cycles -> frame_err one cycle; rx_data keeps its previous value 0xA5; no start accepted until line high; a following 0x12 frame is received correctly.
4. rst_n pulsed low during data bit 4 of 0xF0 -> all outputs 0 immediately (async); no rx_valid or frame_err; the next frame 0x81 is received correctly.
5. Line held 1 for 50 cycles after reset -> state IDLE; rx_busy=0; no pulses.
6. With SERIAL_RX_SYNC_EN, repeat scenario 1 -> rx_valid in cycle 22, rx_data=0xA5.
